clock_set_ctrl: RTL
===================

// Module: clock_set_ctrl
// PURPOSE
//   Time-setting controller for the digital clock. Consumes the one-cycle
//   key_vld pulses from key_module and sequences the hour/min/sec counter
//   datapath through RUN and three SET modes, issuing single-cycle adjust
//   pulses, a run enable for the time base and per-field blink masks for display.
// PARAMETERS
//   HALF_SEC_CYC  25_000_000  clk cycles per blink half-period (0.5 s @ 50 MHz)
//   TIMEOUT_S     10          sec_tick count with no key activity before SET->RUN
// PORTS
//   clk         in   1  system clock, 50 MHz
//   rst_n       in   1  asynchronous active-low reset
//   key_vld     in   3  debounced key pulses: [0]=MODE [1]=UP [2]=DOWN
//   sec_tick    in   1  1-cycle pulse once per second from time base
//   mode        out  2  0=RUN 1=SET_HR 2=SET_MIN 3=SET_SEC
//   run_en      out  1  1 = time base counts; 0 = clock frozen for setting
//   adj_up      out  3  1-cycle increment pulse, one-hot field [2]=hr [1]=min [0]=sec
//   adj_dn      out  3  1-cycle decrement pulse, same field encoding
//   blink_mask  out  3  1 = display blanks that field (same encoding)
// BEHAVIOUR
//   - One clock domain; rst_n asserted -> immediately (async): mode=0, run_en=1,
//     adj_up=0, adj_dn=0, blink_mask=0, blink counter/phase=0, timeout count=0.
//   - All outputs registered; key_vld/sec_tick sampled at edge n -> effect at n+1.
//   - FSM: RUN -MODE-> SET_HR -MODE-> SET_MIN -MODE-> SET_SEC -MODE-> RUN.
//     Any SET state -timeout-> RUN. No other transitions.
//   - run_en = (state==RUN), updated with the state register.
//   - Key priority per cycle: MODE > UP/DOWN. MODE present -> state advances,
//     UP/DOWN in same cycle discarded. UP and DOWN together (no MODE) -> no action.
//   - In SET_x, lone UP -> adj_up = field bit of x for exactly one cycle; lone
//     DOWN -> adj_dn likewise. adj_up/adj_dn never both nonzero; never >1 bit set.
//   - In RUN, UP/DOWN ignored (no pulses, no state change). Field wrap
//     (23->0, 0->59 etc.) belongs to the datapath, not this block.
//   - Timeout: counter width $clog2(TIMEOUT_S+1); counts sec_tick only in SET
//     states; cleared by any nonzero key_vld, on entry to any state, and in RUN.
//     Key and sec_tick in the same cycle -> key wins (count cleared). When the
//     count reaches TIMEOUT_S on a sec_tick -> next cycle mode=0, run_en=1.
//   - Blink: cycle counter 0..HALF_SEC_CYC-1 toggles blink_phase on wrap. Counter
//     and phase cleared to 0 (field visible) on any key_vld and on every state
//     change, so an edited value shows immediately.
//   - blink_mask = field bit of current SET state when blink_phase=1, else 0;
//     always 0 in RUN.
//   - Reset mid-SET abandons setting; no adjust pulse is emitted out of reset.
// TESTING (bench overrides HALF_SEC_CYC=4, TIMEOUT_S=3)
//   1 Release reset, idle 10 cycles -> mode=0, run_en=1, adj_*=0, blink_mask=0;
//     UP and DOWN pulses in RUN -> no adj pulses, mode stays 0.
//   2 MODE pulse x4 -> mode 1,2,3,0 each one cycle after its pulse; run_en=0 in
//     modes 1-3, back to 1 in mode 0.
//   3 In SET_MIN: UP -> adj_up=3'b010 exactly 1 cycle; DOWN -> adj_dn=3'b010;
//     UP+DOWN together -> nothing; MODE+UP -> mode=3, adj_up stays 0.
//   4 In SET_HR with no keys: 3 sec_ticks -> mode=0, run_en=1 the cycle after the
//     3rd; repeat with UP on the 2nd tick's cycle -> needs 3 further ticks.
//   5 In SET_HR: blink_mask 000 for 4 cycles, 100 for 4, repeating; UP mid-blank
//     -> blink_mask=000 next cycle and counter restarts.
//   6 Assert rst_n=0 between edges while in SET_SEC -> mode=0, run_en=1,
//     blink_mask=0 before the next clk edge; no adj pulse after release.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks RUN -> SET_HR -> SET_MIN -> SET_SEC on MODE,
// emits one-cycle adjust pulses, a run enable, and per-field blink masks.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_RUN     | time base counting, UP/DOWN ignored
// ST_SET_HR  | time frozen, UP/DOWN adjust hours, hours blink
// ST_SET_MIN | time frozen, UP/DOWN adjust minutes, minutes blink
// ST_SET_SEC | time frozen, UP/DOWN adjust seconds, seconds blink
module clock_set_ctrl #(
  parameter int HALF_SEC_CYC = 25_000_000,
  parameter int TIMEOUT_S    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_vld,
  input  logic       sec_tick,
  output logic [1:0] mode,
  output logic       run_en,
  output logic [2:0] adj_up,
  output logic [2:0] adj_dn,
  output logic [2:0] blink_mask
);

  localparam int BW = (HALF_SEC_CYC > 1) ? $clog2(HALF_SEC_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            run_en_q, run_en_d;
  logic [2:0]      adj_up_q, adj_up_d;
  logic [2:0]      adj_dn_q, adj_dn_d;
  logic [2:0]      blink_mask_q, blink_mask_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic            mode_key, lone_up, lone_dn, any_key;

  function automatic logic [2:0] field_bit(input state_t s);
    case (s)
      ST_SET_HR:  field_bit = 3'b100;
      ST_SET_MIN: field_bit = 3'b010;
      ST_SET_SEC: field_bit = 3'b001;
      default:    field_bit = 3'b000;
    endcase
  endfunction

  always_comb begin
    mode_key      = key_vld[0];
    lone_up       = key_vld[1] & ~key_vld[2];
    lone_dn       = key_vld[2] & ~key_vld[1];
    any_key       = |key_vld;

    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    adj_up_d      = 3'b000;
    adj_dn_d      = 3'b000;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (mode_key) begin
      case (state_q)
        ST_RUN:     state_d = ST_SET_HR;
        ST_SET_HR:  state_d = ST_SET_MIN;
        ST_SET_MIN: state_d = ST_SET_SEC;
        default:    state_d = ST_RUN;
      endcase
    end else if (state_q != ST_RUN) begin
      if (lone_up) adj_up_d = field_bit(state_q);
      if (lone_dn) adj_dn_d = field_bit(state_q);
      // a key in the same cycle as a tick restarts the idle count instead
      if (sec_tick && !any_key) begin
        if (tmo_cnt_q == TW'(TIMEOUT_S - 1)) state_d = ST_RUN;
        else                                 tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end

    if (any_key || (state_d != state_q) || (state_q == ST_RUN))
      tmo_cnt_d = '0;

    // restart blink with the field visible so an edit shows at once
    if (any_key || (state_d != state_q)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BW'(HALF_SEC_CYC - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BW'(1);
    end

    blink_mask_d = blink_phase_d ? field_bit(state_d) : 3'b000;
    run_en_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      run_en_q      <= 1'b1;
      adj_up_q      <= 3'b000;
      adj_dn_q      <= 3'b000;
      blink_mask_q  <= 3'b000;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      run_en_q      <= run_en_d;
      adj_up_q      <= adj_up_d;
      adj_dn_q      <= adj_dn_d;
      blink_mask_q  <= blink_mask_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign mode       = state_q;
  assign run_en     = run_en_q;
  assign adj_up     = adj_up_q;
  assign adj_dn     = adj_dn_q;
  assign blink_mask = blink_mask_q;

endmodule
